// File: rtl/ppi8255.sv
// ppi8255 -- 8255-style programmable peripheral interface for the Atom I/O page.
//
// Three 8-bit ports (PA, PB, PC) with a writable control word, PC bit
// set/reset, per-group direction control, input synchronisers and mode 1
// strobed input on port A (STB_A_n on PC4, IBF_A on PC5, INTR_A on PC3).
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   cs, rnw, addr, din  registered CPU bus (addr 0 PA, 1 PB, 2 PC, 3 control)
//   dout                read data, combinational from current state
//   pa/pb/pc_in         asynchronous pin inputs
//   pa/pb/pc_out        output latches (PC3/PC5 carry INTR_A/IBF_A in mode 1)
//   pa/pb/pc_oe         per-bit output enable, 1 = drive
//   intr_a              port A interrupt request
module ppi8255 #(
  parameter logic [7:0] RESET_CW    = 8'h9B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       rnw,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_oe,
  output logic [7:0] pc_oe,
  output logic       intr_a
);

  logic [7:0] cw_q, cw_d;
  logic [7:0] pa_lat_q, pa_lat_d;
  logic [7:0] pb_lat_q, pb_lat_d;
  logic [7:0] pc_lat_q, pc_lat_d;
  logic [7:0] pa_hold_q, pa_hold_d;
  logic       ibf_q, ibf_d;
  logic       intr_q, intr_d;
  logic       inte_q, inte_d;
  logic       stb_prev_q, stb_prev_d;

  logic [7:0] pa_sync_q [SYNC_STAGES];
  logic [7:0] pa_sync_d [SYNC_STAGES];
  logic [7:0] pb_sync_q [SYNC_STAGES];
  logic [7:0] pb_sync_d [SYNC_STAGES];
  logic [7:0] pc_sync_q [SYNC_STAGES];
  logic [7:0] pc_sync_d [SYNC_STAGES];

  logic [7:0] pa_s, pb_s, pc_s;
  logic       mode1, stb_s, stb_fall, stb_rise, rd_pa, wr;
  logic [7:0] pc_rd;

  assign pa_s  = pa_sync_q[SYNC_STAGES-1];
  assign pb_s  = pb_sync_q[SYNC_STAGES-1];
  assign pc_s  = pc_sync_q[SYNC_STAGES-1];
  assign mode1 = (cw_q[6:5] != 2'b00);
  assign stb_s = pc_s[4];
  assign stb_fall = stb_prev_q & ~stb_s;
  assign stb_rise = ~stb_prev_q & stb_s;
  assign rd_pa = cs & rnw & (addr == 2'd0);
  assign wr    = cs & ~rnw;
  assign stb_prev_d = stb_s;

  always_comb begin
    pa_sync_d[0] = pa_in;
    pb_sync_d[0] = pb_in;
    pc_sync_d[0] = pc_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      pa_sync_d[i] = pa_sync_q[i-1];
      pb_sync_d[i] = pb_sync_q[i-1];
      pc_sync_d[i] = pc_sync_q[i-1];
    end
  end

  always_comb begin
    cw_d      = cw_q;
    pa_lat_d  = pa_lat_q;
    pb_lat_d  = pb_lat_q;
    pc_lat_d  = pc_lat_q;
    pa_hold_d = pa_hold_q;
    ibf_d     = ibf_q;
    intr_d    = intr_q;
    inte_d    = inte_q;

    // Handshake events are ordered so that a strobe capture landing on the
    // same cycle as a PA read leaves IBF set (new data pending) while the
    // read still clears INTR.
    if (mode1) begin
      if (stb_rise && ibf_q && inte_q) intr_d = 1'b1;
      if (rd_pa) begin
        ibf_d  = 1'b0;
        intr_d = 1'b0;
      end
      if (stb_fall) begin
        pa_hold_d = pa_s;
        ibf_d     = 1'b1;
      end
    end

    if (wr) begin
      unique case (addr)
        2'd0: pa_lat_d = din;
        2'd1: pb_lat_d = din;
        2'd2: pc_lat_d = din;
        default: begin
          if (din[7]) begin
            cw_d     = din;
            pa_lat_d = 8'h00;
            pb_lat_d = 8'h00;
            pc_lat_d = 8'h00;
            ibf_d    = 1'b0;
            intr_d   = 1'b0;
            inte_d   = 1'b0;
          end else if (mode1 && din[3:1] == 3'd4) begin
            inte_d = din[0];
          end else if (!(mode1 && (din[3:1] == 3'd3 || din[3:1] == 3'd5))) begin
            pc_lat_d[din[3:1]] = din[0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cw_q       <= RESET_CW;
      pa_lat_q   <= 8'h00;
      pb_lat_q   <= 8'h00;
      pc_lat_q   <= 8'h00;
      pa_hold_q  <= 8'h00;
      ibf_q      <= 1'b0;
      intr_q     <= 1'b0;
      inte_q     <= 1'b0;
      // Idle-high history so reset release never looks like a strobe edge.
      stb_prev_q <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pa_sync_q[i] <= 8'hFF;
        pb_sync_q[i] <= 8'hFF;
        pc_sync_q[i] <= 8'hFF;
      end
    end else begin
      cw_q       <= cw_d;
      pa_lat_q   <= pa_lat_d;
      pb_lat_q   <= pb_lat_d;
      pc_lat_q   <= pc_lat_d;
      pa_hold_q  <= pa_hold_d;
      ibf_q      <= ibf_d;
      intr_q     <= intr_d;
      inte_q     <= inte_d;
      stb_prev_q <= stb_prev_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pa_sync_q[i] <= pa_sync_d[i];
        pb_sync_q[i] <= pb_sync_d[i];
        pc_sync_q[i] <= pc_sync_d[i];
      end
    end
  end

  assign pa_out = pa_lat_q;
  assign pb_out = pb_lat_q;
  assign pa_oe  = {8{~(mode1 | cw_q[4])}};
  assign pb_oe  = {8{~cw_q[1]}};
  assign intr_a = intr_q;

  always_comb begin
    pc_oe  = {{4{~cw_q[3]}}, {4{~cw_q[0]}}};
    pc_out = pc_lat_q;
    pc_rd  = {cw_q[3] ? pc_s[7:4] : pc_lat_q[7:4],
              cw_q[0] ? pc_s[3:0] : pc_lat_q[3:0]};
    if (mode1) begin
      pc_oe[3]  = 1'b1;
      pc_oe[4]  = 1'b0;
      pc_oe[5]  = 1'b1;
      pc_out[3] = intr_q;
      pc_out[5] = ibf_q;
      pc_rd[3]  = intr_q;
      pc_rd[4]  = inte_q;
      pc_rd[5]  = ibf_q;
    end
  end

  always_comb begin
    dout = 8'h00;
    unique case (addr)
      2'd0: dout = mode1 ? pa_hold_q : (cw_q[4] ? pa_s : pa_lat_q);
      2'd1: dout = cw_q[1] ? pb_s : pb_lat_q;
      2'd2: dout = pc_rd;
      default: dout = cw_q;
    endcase
  end

endmodule

// File: doc/ppi8255.md
# ppi8255

Parametrised 8255-style programmable peripheral interface for the Atom I/O page, replacing the fixed-direction PIA register stub at 0xB000–0xB003. It provides:
- a writable control word;
- port C bit set/reset;
- per-group direction control;
- input synchronisers;
- mode 1 strobed input with IBF/INTR handshake on port A (for keyboard/cassette capture).

It sits on the registered CPU bus (one access per `clk` cycle) and drives `pia_dout` into the data multiplexor.

## Interface
Parameters:
- `RESET_CW`, 8'h9B — control word loaded at reset; Atom top-level uses 8'h8A (PA out, PB in, PC lower out, PC upper in).
- `SYNC_STAGES`, 2 — flip-flop stages on every pin input (`pa_in`, `pb_in`, `pc_in`); legal 1–4.

Ports:
- `clk` in 1 — system clock, CPU rate; all state updates on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `cs` in 1 — chip select, one cycle per bus access.
- `rnw` in 1 — 1 read, 0 write.
- `addr` in 2 — 0 PA, 1 PB, 2 PC, 3 control.
- `din` in 8 — write data.
- `dout` out 8 — read data, combinational from current state.
- `pa_in`, `pb_in`, `pc_in` in 8 each — pin inputs (async).
- `pa_out`, `pb_out`, `pc_out` out 8 each — output latches.
- `pa_oe`, `pb_oe`, `pc_oe` out 8 each — per-bit output enable, 1 = drive.
- `intr_a` out 1 — port A interrupt request (mirror of INTR_A).

## Operation
Control register `cw` (write addr 3):
- Write with `din[7]`=1: mode set.
  - Load `cw`.
  - Clear `pa_out`, `pb_out`, `pc_out` latches.
  - Clear IBF_A, INTR_A, INTE_A.
- Write with `din[7]`=0: bit set/reset. PC bit `din[3:1]` <= `din[0]`; `cw` is unchanged.
  - In mode 1, BSR on bit 4 writes INTE_A instead of the latch.
  - BSR on bits 3 and 5 is ignored.
- `cw` fields:
  - [6:5] group A mode: 00 = mode 0; 01, 1x = mode 1 (mode 2 not supported).
  - [4] PA input.
  - [3] PC[7:4] input.
  - [2] group B mode (stored and read back; behaves as mode 0).
  - [1] PB input.
  - [0] PC[3:0] input.
- Read of addr 3 returns `cw`.

Mode 0:
- Port output enable = ~direction bit, replicated across the port or nibble.
- Reading an output port returns its latch. Reading an input port returns the synchronised pin.
- Writing an input port updates its latch only; the latch is not visible on read.

Mode 1, group A:
- PC4 is STB_A_n (input, `pc_oe[4]`=0).
- PC5 is IBF_A (`pc_oe[5]`=1, `pc_out[5]`=IBF_A).
- PC3 is INTR_A (`pc_oe[3]`=1, `pc_out[3]`=INTR_A).
- PA is forced to input.
- PC[7:6] and PC[2:0] follow the direction bits.
- Falling edge of synchronised STB_A_n:
  - The synchronised `pa_in` is captured into `pa_hold`.
  - IBF_A <= 1.
- Rising edge of synchronised STB_A_n with IBF_A=1 and INTE_A=1: INTR_A <= 1.
- Read of PA (`cs & rnw & addr==0`):
  - Returns `pa_hold`.
  - At that clock edge, IBF_A <= 0 and INTR_A <= 0.
- PC read returns pins/latches per direction, with bits 3, 4, 5 replaced by INTR_A, INTE_A, IBF_A.
- A strobe falling edge while IBF_A=1 overwrites `pa_hold` (overrun, no flag).

Boundary cases:
- Falling strobe edge on the same cycle as a PA read:
  - Capture wins: IBF_A ends at 1 and `pa_hold` holds the new data.
  - INTR_A clears.
  - The read returns the old `pa_hold`.
- Mode set to mode 0 while IBF_A=1 clears the handshake immediately.
- Edge detector history registers are reset to 1 (STB idle high), so reset release produces no spurious edge.
- Writes with `cs`=0 or `rnw`=1 have no effect.

Reset (`reset_n`=0, asynchronous):
- `cw` = `RESET_CW`.
- All latches and `pa_hold` = 0.
- IBF_A, INTR_A, INTE_A = 0.
- Synchroniser stages = 1.
- OE outputs follow `RESET_CW`.
- `intr_a` = 0.

## Timing
- Register writes take effect at the rising edge of the write cycle; outputs change after that edge.
- `dout` is valid in the same cycle as `cs`/`addr` (combinational); read side effects occur at the end of that cycle.
- Pin-to-readable latency: `SYNC_STAGES` cycles.
- STB_A_n falling edge to IBF_A=1 on `pc_out[5]`: `SYNC_STAGES`+1 cycles.
- STB_A_n rising edge to `intr_a`: `SYNC_STAGES`+1 cycles.
- Minimum STB_A_n low and high time: 2 cycles each.

## Test plan
- Reset with `RESET_CW`=8'h8A:
  - `pa_oe`=8'hFF, `pb_oe`=8'h00, `pc_oe`=8'h0F, all outputs 0.
  - Read addr 3 returns 8'h8A.
- Mode 0:
  - Write 8'h5A to PA: `pa_out`=8'h5A next cycle, and PA reads back 8'h5A.
  - Drive `pb_in`=8'hC3: PB reads 8'hC3 from `SYNC_STAGES` cycles after the change.
- BSR:
  - Write 8'h07 to addr 3: `pc_out[3]`=1, `cw` unchanged.
  - Then write 8'h06: `pc_out[3]`=0.
  - Mode-set write 8'h8A after the PC latch = 8'h0F: `pc_out`=8'h00.
- Mode 1 handshake:
  - Write cw=8'hB0, then BSR 8'h09 (INTE_A=1).
  - Pulse `pc_in[4]` low for 3 cycles with `pa_in`=8'hA5: IBF_A=1, then `intr_a`=1 after the rising edge.
  - Read PA: returns 8'hA5; IBF_A and `intr_a` = 0 next cycle.
- Simultaneous strobe and read:
  - Align the synchronised STB falling edge with a PA read.
  - The read returns the old data, IBF_A stays 1, and the next read returns the new data.
- Reset mid-handshake:
  - Assert `reset_n`=0 asynchronously with IBF_A=1 and `intr_a`=1: both clear without a clock edge.
  - After release, no IBF is set with `pc_in[4]` held high.
